// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response encoding and address-decode helper for the
// register file and its write controller.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  // Number of byte-offset address bits below the register index.
  function automatic int addr_lsb(input int data_size);
    return $clog2(data_size / 8);
  endfunction

endpackage

// File: rtl/axi4_lite_regfile_wr_ctrl.sv
// AXI4-Lite write path: independent AW/W holding buffers, commit when both
// are full, and the B response held until the master accepts it.
module axi4_lite_regfile_wr_ctrl
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int NUM_REGS     = 8,
  parameter int IDX_W        = 3
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDRESS_SIZE-1:0] s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_SIZE-1:0]    s_axi_wdata,
  input  logic [DATA_SIZE/8-1:0]  s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic                    commit_o,
  output logic [IDX_W-1:0]        index_o,
  output logic [DATA_SIZE-1:0]    data_o,
  output logic [DATA_SIZE/8-1:0]  strb_o,
  output logic                    err_o
);

  localparam int ADDR_LSB = addr_lsb(DATA_SIZE);

  logic                    aw_full_q, aw_full_d;
  logic [ADDRESS_SIZE-1:0] aw_addr_q, aw_addr_d;
  logic                    w_full_q, w_full_d;
  logic [DATA_SIZE-1:0]    w_data_q, w_data_d;
  logic [DATA_SIZE/8-1:0]  w_strb_q, w_strb_d;
  logic                    bvalid_q, bvalid_d;
  resp_t                   bresp_q, bresp_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;

  logic                    aw_hs_s, w_hs_s, commit_s, err_s;
  logic [ADDRESS_SIZE-1:0] word_addr_s;

  assign aw_hs_s     = s_axi_awvalid & awready_q;
  assign w_hs_s      = s_axi_wvalid & wready_q;
  assign commit_s    = aw_full_q & w_full_q;
  assign word_addr_s = aw_addr_q >> ADDR_LSB;
  assign err_s       = (word_addr_s >= ADDRESS_SIZE'(NUM_REGS));

  // Next-state for buffers, B response and the registered ready flags.
  always_comb begin
    aw_full_d = aw_full_q | aw_hs_s;
    aw_addr_d = aw_hs_s ? s_axi_awaddr : aw_addr_q;
    w_full_d  = w_full_q | w_hs_s;
    w_data_d  = w_hs_s ? s_axi_wdata : w_data_q;
    w_strb_d  = w_hs_s ? s_axi_wstrb : w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (!aresetn) begin
      aw_full_d = 1'b0;
      aw_addr_d = '0;
      w_full_d  = 1'b0;
      w_data_d  = '0;
      w_strb_d  = '0;
      bvalid_d  = 1'b0;
      bresp_d   = OKAY;
    end else if (commit_s) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = err_s ? SLVERR : OKAY;
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d  = 1'b0;
    end else begin
      bvalid_d  = bvalid_q;
    end
    // Readies are registered from next state so they are low throughout reset.
    awready_d = aresetn & ~aw_full_d & ~bvalid_d;
    wready_d  = aresetn & ~w_full_d & ~bvalid_d;
  end

  // Write-path state register.
  always_ff @(posedge aclk) begin
    aw_full_q <= aw_full_d;
    aw_addr_q <= aw_addr_d;
    w_full_q  <= w_full_d;
    w_data_q  <= w_data_d;
    w_strb_q  <= w_strb_d;
    bvalid_q  <= bvalid_d;
    bresp_q   <= bresp_d;
    awready_q <= awready_d;
    wready_q  <= wready_d;
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign commit_o      = commit_s;
  assign index_o       = word_addr_s[IDX_W-1:0];
  assign data_o        = w_data_q;
  assign strb_o        = w_strb_q;
  assign err_o         = err_s;

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS byte-writable registers, with a
// one-cycle-latency read path and a per-register write strobe.
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int                   ADDRESS_SIZE = 32,
  parameter int                   DATA_SIZE    = 32,
  parameter int                   NUM_REGS     = 8,
  parameter logic [DATA_SIZE-1:0] RESET_VALUE  = '0
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [ADDRESS_SIZE-1:0]       s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [DATA_SIZE-1:0]          s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  input  logic [ADDRESS_SIZE-1:0]       s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [DATA_SIZE-1:0]          s_axi_wdata,
  input  logic [DATA_SIZE/8-1:0]        s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [NUM_REGS*DATA_SIZE-1:0] regs_o,
  output logic [NUM_REGS-1:0]           reg_wr_pulse_o
);

  localparam int ADDR_LSB = addr_lsb(DATA_SIZE);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int NBYTES   = DATA_SIZE / 8;

  logic                 wr_commit_s, wr_err_s;
  logic [IDX_W-1:0]     wr_idx_s;
  logic [DATA_SIZE-1:0] wr_data_s;
  logic [NBYTES-1:0]    wr_strb_s;

  axi4_lite_regfile_wr_ctrl #(
    .ADDRESS_SIZE(ADDRESS_SIZE),
    .DATA_SIZE   (DATA_SIZE),
    .NUM_REGS    (NUM_REGS),
    .IDX_W       (IDX_W)
  ) u_wr_ctrl (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .commit_o     (wr_commit_s),
    .index_o      (wr_idx_s),
    .data_o       (wr_data_s),
    .strb_o       (wr_strb_s),
    .err_o        (wr_err_s)
  );

  // Packed so that register i lands at bits [i*DATA_SIZE +: DATA_SIZE].
  logic [NUM_REGS-1:0][DATA_SIZE-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                pulse_q, pulse_d;

  // Register array update with byte enables, plus the commit strobe.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = RESET_VALUE;
      end
    end else if (wr_commit_s && !wr_err_s) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (wr_strb_s[k]) begin
          regs_d[wr_idx_s][8*k +: 8] = wr_data_s[8*k +: 8];
        end else begin
          regs_d[wr_idx_s][8*k +: 8] = regs_q[wr_idx_s][8*k +: 8];
        end
      end
      pulse_d[wr_idx_s] = 1'b1;
    end else begin
      pulse_d = '0;
    end
  end

  // Register array and strobe state.
  always_ff @(posedge aclk) begin
    regs_q  <= regs_d;
    pulse_q <= pulse_d;
  end

  logic                    rvalid_q, rvalid_d;
  logic [DATA_SIZE-1:0]    rdata_q, rdata_d;
  resp_t                   rresp_q, rresp_d;
  logic                    arready_q, arready_d;
  logic                    ar_hs_s, rd_err_s;
  logic [ADDRESS_SIZE-1:0] rd_word_s;
  logic [IDX_W-1:0]        rd_idx_s;

  assign ar_hs_s   = s_axi_arvalid & arready_q;
  assign rd_word_s = s_axi_araddr >> ADDR_LSB;
  assign rd_err_s  = (rd_word_s >= ADDRESS_SIZE'(NUM_REGS));
  assign rd_idx_s  = rd_word_s[IDX_W-1:0];

  // Read channel: samples regs_q, so a write committing on the same edge is not seen.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (!aresetn) begin
      rvalid_d = 1'b0;
      rdata_d  = '0;
      rresp_d  = OKAY;
    end else if (ar_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_err_s ? '0 : regs_q[rd_idx_s];
      rresp_d  = rd_err_s ? SLVERR : OKAY;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
    arready_d = aresetn & ~rvalid_d;
  end

  // Read-channel state register.
  always_ff @(posedge aclk) begin
    rvalid_q  <= rvalid_d;
    rdata_q   <= rdata_d;
    rresp_q   <= rresp_d;
    arready_q <= arready_d;
  end

  assign s_axi_arready  = arready_q;
  assign s_axi_rvalid   = rvalid_q;
  assign s_axi_rdata    = rdata_q;
  assign s_axi_rresp    = rresp_q;
  assign regs_o         = regs_q;
  assign reg_wr_pulse_o = pulse_q;

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed bench for axi4_lite_regfile: a vector table of single writes/reads
// followed by hand-written multi-cycle sequences.
module tb_axi4_lite_regfile;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [AW-1:0]    araddr, awaddr;
  logic             arvalid, arready, rvalid, rready;
  logic [DW-1:0]    rdata, wdata;
  logic [1:0]       rresp, bresp;
  logic             awvalid, awready, wvalid, wready, bvalid, bready;
  logic [DW/8-1:0]  wstrb;
  logic [NR*DW-1:0] regs;
  logic [NR-1:0]    pulse;

  always #5 aclk = ~aclk;

  axi4_lite_regfile #(
    .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .NUM_REGS(NR), .RESET_VALUE(32'h0000_0000)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .regs_o(regs), .reg_wr_pulse_o(pulse)
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          idx;    // register the model updates on a write, -1 for none
    logic [31:0] val;    // new register value (write) or expected rdata (read)
    logic [7:0]  pulse;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] model[NR];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s reg%0d", tag, i), regs[i*DW +: DW], model[i]);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp_resp, input logic [7:0] exp_pulse, input string tag);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin tick(); n++; end
    check({tag, " aw_w_ready"}, 32'(awready && wready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check({tag, " bvalid_pre"}, 32'(bvalid), 32'd0);
    tick();
    check({tag, " bvalid"}, 32'(bvalid), 32'd1);
    check({tag, " bresp"}, 32'(bresp), 32'(exp_resp));
    check({tag, " pulse"}, 32'(pulse), 32'(exp_pulse));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check({tag, " bvalid_done"}, 32'(bvalid), 32'd0);
    check({tag, " pulse_done"}, 32'(pulse), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string tag);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    check({tag, " arready"}, 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    check({tag, " rvalid"}, 32'(rvalid), 32'd1);
    check({tag, " rdata"}, rdata, exp_data);
    check({tag, " rresp"}, 32'(rresp), 32'(exp_resp));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check({tag, " rvalid_done"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00,  1, 32'hDEAD_BEEF, 8'h02};
    vecs[1] = '{1'b0, 32'h0000_0008, 32'h1122_3344, 4'hF, 2'b00,  2, 32'h1122_3344, 8'h04};
    vecs[2] = '{1'b0, 32'h0000_001C, 32'hA5A5_A5A5, 4'hC, 2'b00,  7, 32'hA5A5_0000, 8'h80};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 2'b00,  0, 32'h0000_0000, 8'h01};
    vecs[4] = '{1'b0, 32'h0000_0020, 32'h1234_5678, 4'hF, 2'b10, -1, 32'h0000_0000, 8'h00};
    vecs[5] = '{1'b0, 32'h0000_0007, 32'h0000_0011, 4'h1, 2'b00,  1, 32'hDEAD_BE11, 8'h02};
    vecs[6] = '{1'b1, 32'h0000_0004, 32'h0000_0000, 4'h0, 2'b00, -1, 32'hDEAD_BE11, 8'h00};
    vecs[7] = '{1'b1, 32'h0000_0020, 32'h0000_0000, 4'h0, 2'b10, -1, 32'h0000_0000, 8'h00};
    vecs[8] = '{1'b1, 32'h0000_001E, 32'h0000_0000, 4'h0, 2'b00, -1, 32'hA5A5_0000, 8'h00};
    vecs[9] = '{1'b1, 32'h0000_0400, 32'h0000_0000, 4'h0, 2'b10, -1, 32'h0000_0000, 8'h00};
    for (int i = 0; i < NR; i++) model[i] = 32'h0000_0000;

    aresetn = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) tick();
    check("rst arready", 32'(arready), 32'd0);
    check("rst awready", 32'(awready), 32'd0);
    check("rst wready", 32'(wready), 32'd0);
    check("rst rvalid", 32'(rvalid), 32'd0);
    check("rst bvalid", 32'(bvalid), 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst rresp", 32'(rresp), 32'd0);
    check("rst bresp", 32'(bresp), 32'd0);
    check("rst pulse", 32'(pulse), 32'd0);
    check_regs("rst");
    aresetn = 1'b1;
    tick();
    check("post_rst awready", 32'(awready), 32'd1);
    check("post_rst arready", 32'(arready), 32'd1);

    // Table of single transactions
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_rd) begin
        do_read(vecs[i].addr, vecs[i].val, vecs[i].resp, $sformatf("vec%0d", i));
      end else begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, vecs[i].pulse,
                 $sformatf("vec%0d", i));
        if (vecs[i].idx >= 0) model[vecs[i].idx] = vecs[i].val;
        check_regs($sformatf("vec%0d", i));
      end
    end

    // W three cycles ahead of AW, partial strobe, then bready stalled 5 cycles
    wdata = 32'h0000_ABCD; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("wfirst wready c%0d", c), 32'(wready), 32'd0);
      check($sformatf("wfirst awready c%0d", c), 32'(awready), 32'd1);
      if (c < 2) tick();
    end
    awaddr = 32'h0000_0008; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("wfirst bvalid_pre", 32'(bvalid), 32'd0);
    check("wfirst wready_full", 32'(wready), 32'd0);
    tick();
    model[2] = 32'h1122_ABCD;
    check("wfirst pulse", 32'(pulse), 32'h04);
    check_regs("wfirst");
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bstall bvalid c%0d", c), 32'(bvalid), 32'd1);
      check($sformatf("bstall bresp c%0d", c), 32'(bresp), 32'd0);
      check($sformatf("bstall awready c%0d", c), 32'(awready), 32'd0);
      check($sformatf("bstall wready c%0d", c), 32'(wready), 32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bstall bvalid_done", 32'(bvalid), 32'd0);
    check("bstall awready_back", 32'(awready), 32'd1);
    check("bstall wready_back", 32'(wready), 32'd1);

    // rready stalled 5 cycles
    araddr = 32'h0000_0008; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("rstall rvalid c%0d", c), 32'(rvalid), 32'd1);
      check($sformatf("rstall rdata c%0d", c), rdata, 32'h1122_ABCD);
      check($sformatf("rstall arready c%0d", c), 32'(arready), 32'd0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rstall rvalid_done", 32'(rvalid), 32'd0);
    check("rstall arready_back", 32'(arready), 32'd1);

    // Read handshake on the same edge as a write commit to the same register
    awaddr = 32'h0000_0004; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h0000_0004; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    model[1] = 32'hCAFE_F00D;
    check("rw_same rvalid", 32'(rvalid), 32'd1);
    check("rw_same rdata_old", rdata, 32'hDEAD_BE11);
    check("rw_same bvalid", 32'(bvalid), 32'd1);
    check("rw_same pulse", 32'(pulse), 32'h02);
    check_regs("rw_same");
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    do_read(32'h0000_0004, 32'hCAFE_F00D, 2'b00, "rw_after");

    // Reset between AW and W acceptance
    awaddr = 32'h0000_0000; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("midrst aw_held", 32'(awready), 32'd0);
    aresetn = 1'b0;
    wdata = 32'h5555_5555; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    for (int i = 0; i < NR; i++) model[i] = 32'h0000_0000;
    check("midrst awready", 32'(awready), 32'd0);
    check("midrst wready", 32'(wready), 32'd0);
    check("midrst arready", 32'(arready), 32'd0);
    check("midrst bvalid", 32'(bvalid), 32'd0);
    check("midrst rdata", rdata, 32'd0);
    check_regs("midrst");
    aresetn = 1'b1;
    tick();
    check("midrst awready_back", 32'(awready), 32'd1);
    check("midrst wready_back", 32'(wready), 32'd1);
    check("midrst arready_back", 32'(arready), 32'd1);
    tick();
    wvalid = 1'b0;
    tick();
    tick();
    check("midrst no_commit bvalid", 32'(bvalid), 32'd0);
    check("midrst no_commit pulse", 32'(pulse), 32'd0);
    check("midrst w_buffered", 32'(wready), 32'd0);
    check_regs("midrst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
